// File: rtl/core_boot_controller.sv
// Boot sequencer: streams a program image into instruction memory, then
// releases the core from reset, starts it and times its run.
module core_boot_controller #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int RESET_CYCLES = 4,
  parameter int CNT_BITS     = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    boot_req,
  input  logic [ADDRESS_BITS-1:0] boot_addr,
  input  logic [CNT_BITS-1:0]     cycle_limit,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic [DATA_WIDTH-1:0]   host_data,
  input  logic                    host_last,
  output logic                    imem_we,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]   imem_wdata,
  output logic                    core_reset,
  output logic                    core_start,
  output logic [ADDRESS_BITS-1:0] prog_address,
  input  logic                    core_halt,
  output logic                    report,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic [CNT_BITS-1:0]     run_cycles
);

  localparam int HB = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HB-1:0] HOLD_LAST = HB'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, HOLD_RST, START, RUN, REPORT, DONE
  } state_t;

  state_t                  state;
  logic [ADDRESS_BITS-1:0] base;
  logic [ADDRESS_BITS-1:0] idx;
  logic [CNT_BITS-1:0]     limit;
  logic [HB-1:0]           hold_cnt;
  logic [CNT_BITS-1:0]     run_next;
  logic                    accept;

  assign host_ready = (state == LOAD);
  assign accept     = host_valid && host_ready;
  assign busy       = (state == LOAD) || (state == HOLD_RST) ||
                      (state == START) || (state == RUN) ||
                      (state == REPORT);
  assign done       = (state == DONE);

  // Counter sticks at all-ones rather than wrapping on very long runs
  assign run_next = (run_cycles == '1) ? run_cycles : run_cycles + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      base         <= '0;
      idx          <= '0;
      limit        <= '0;
      hold_cnt     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      core_start   <= 1'b0;
      prog_address <= '0;
      report       <= 1'b0;
      timeout      <= 1'b0;
      run_cycles   <= '0;
    end else begin
      imem_we    <= 1'b0;
      core_start <= 1'b0;
      report     <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (boot_req) begin
            base       <= boot_addr;
            limit      <= cycle_limit;
            idx        <= '0;
            core_reset <= 1'b1;
            timeout    <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= base + idx;
            imem_wdata <= host_data;
            idx        <= idx + 1'b1;
            if (host_last) begin
              hold_cnt <= '0;
              state    <= HOLD_RST;
            end
          end
        end
        HOLD_RST: begin
          if (hold_cnt == HOLD_LAST) begin
            core_reset   <= 1'b0;
            core_start   <= 1'b1;
            prog_address <= base;
            run_cycles   <= '0;
            state        <= START;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        START: state <= RUN;
        RUN: begin
          run_cycles <= run_next;
          // A halt on the budget's last cycle is a normal finish
          if (core_halt) begin
            timeout <= 1'b0;
            report  <= 1'b1;
            state   <= REPORT;
          end else if (limit != '0 && run_next == limit) begin
            timeout <= 1'b1;
            report  <= 1'b1;
            state   <= REPORT;
          end
        end
        REPORT: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_boot_controller.sv
// Directed bench for core_boot_controller: table of boot scenarios
// plus hand-written asynchronous-reset sequences.
module tb_core_boot_controller;

  localparam int DW = 32;
  localparam int AB = 20;
  localparam int RC = 4;
  localparam int CB = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          boot_req = 1'b0;
  logic [AB-1:0] boot_addr = '0;
  logic [CB-1:0] cycle_limit = '0;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic [DW-1:0] host_data = '0;
  logic          host_last = 1'b0;
  logic          imem_we;
  logic [AB-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          core_reset;
  logic          core_start;
  logic [AB-1:0] prog_address;
  logic          core_halt = 1'b0;
  logic          report;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CB-1:0] run_cycles;

  int checks = 0;
  int errors = 0;

  core_boot_controller #(
    .DATA_WIDTH(DW), .ADDRESS_BITS(AB),
    .RESET_CYCLES(RC), .CNT_BITS(CB)
  ) dut (
    .clock(clock), .reset(reset),
    .boot_req(boot_req), .boot_addr(boot_addr),
    .cycle_limit(cycle_limit),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_data(host_data), .host_last(host_last),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_reset(core_reset), .core_start(core_start),
    .prog_address(prog_address), .core_halt(core_halt),
    .report(report), .busy(busy), .done(done),
    .timeout(timeout), .run_cycles(run_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AB-1:0] base;
    int            nwords;
    bit            toggle;
    logic [CB-1:0] limit;
    int            halt_at;
    int            exp_rc;
    bit            exp_to;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(logic [AB-1:0] b, int i);
    return {12'hA5A, b} + DW'(i) * 32'h0000_0111;
  endfunction

  task automatic boot(vec_t v);
    int idx, w, cyc, hc, rc;
    boot_req    = 1'b1;
    boot_addr   = v.base;
    cycle_limit = v.limit;
    @(negedge clock);
    boot_req = 1'b0;
    chk("load_core_reset", core_reset, 1);
    chk("load_busy", busy, 1);
    chk("load_ready", host_ready, 1);
    idx = 0; w = 0; cyc = 0;
    while (idx < v.nwords && cyc < 100) begin
      if (imem_we) begin
        chk("wr_addr", imem_addr, AB'(v.base + AB'(w)));
        chk("wr_data", imem_wdata, word(v.base, w));
        w++;
      end
      host_valid = v.toggle ? (cyc % 2 == 0) : 1'b1;
      host_data  = word(v.base, idx);
      host_last  = (idx == v.nwords - 1);
      if (host_valid && host_ready) idx++;
      @(negedge clock);
      cyc++;
    end
    host_valid = 1'b0;
    host_last  = 1'b0;
    chk("load_done_in_budget", idx, v.nwords);
    chk("hold_ready_low", host_ready, 0);
    hc = 0;
    while (core_reset && hc < 20) begin
      if (imem_we) begin
        chk("wr_addr", imem_addr, AB'(v.base + AB'(w)));
        chk("wr_data", imem_wdata, word(v.base, w));
        w++;
      end
      hc++;
      @(negedge clock);
    end
    chk("write_count", w, v.nwords);
    chk("hold_cycles", hc, RC);
    chk("start_pulse", core_start, 1);
    chk("prog_address", prog_address, v.base);
    @(negedge clock);
    chk("start_one_cycle", core_start, 0);
    rc = 0;
    while (!report && rc < 200) begin
      rc++;
      core_halt = (rc == v.halt_at);
      @(negedge clock);
    end
    core_halt = 1'b0;
    chk("report_seen", report, 1);
    chk("run_len", rc, v.exp_rc);
    chk("run_cycles", run_cycles, v.exp_rc);
    chk("timeout", timeout, v.exp_to);
    @(negedge clock);
    chk("report_one_cycle", report, 0);
    chk("done", done, 1);
    chk("done_not_busy", busy, 0);
    chk("done_core_reset", core_reset, 0);
    chk("done_ready_low", host_ready, 0);
    chk("done_rc_held", run_cycles, v.exp_rc);
  endtask

  initial begin
    int n;
    tbl[0] = '{20'h00100, 3, 1'b0, 10, 3, 3, 1'b0};
    tbl[1] = '{20'h00200, 4, 1'b1, 0, 7, 7, 1'b0};
    tbl[2] = '{20'h00300, 2, 1'b0, 10, 0, 10, 1'b1};
    tbl[3] = '{20'h00400, 2, 1'b0, 5, 5, 5, 1'b0};
    tbl[4] = '{20'hFFFFE, 4, 1'b0, 3, 0, 3, 1'b1};
    tbl[5] = '{20'h00010, 1, 1'b0, 1, 0, 1, 1'b1};

    reset = 1'b1;
    #12;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prog_address", prog_address, 0);
    chk("rst_ready", host_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_core_reset", core_reset, 1);

    for (int i = 0; i < 6; i++) boot(tbl[i]);

    // reset in the middle of LOAD, with a write on the bus
    boot_req = 1'b1; boot_addr = 20'h00700; cycle_limit = 0;
    @(negedge clock);
    boot_req   = 1'b0;
    host_valid = 1'b1;
    host_data  = 32'h1234_5678;
    @(negedge clock);
    chk("midload_we", imem_we, 1);
    #1 reset = 1'b1;
    #1;
    chk("midload_rst_we", imem_we, 0);
    chk("midload_rst_core_reset", core_reset, 1);
    chk("midload_rst_ready", host_ready, 0);
    chk("midload_rst_busy", busy, 0);
    host_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // reset in the middle of RUN
    boot_req = 1'b1; boot_addr = 20'h00500; cycle_limit = 0;
    @(negedge clock);
    boot_req   = 1'b0;
    host_valid = 1'b1;
    host_last  = 1'b1;
    host_data  = 32'h0BAD_F00D;
    @(negedge clock);
    host_valid = 1'b0;
    host_last  = 1'b0;
    n = 0;
    while (!core_start && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("midrun_start_seen", core_start, 1);
    repeat (3) @(negedge clock);
    chk("midrun_run_cycles", run_cycles, 2);
    chk("midrun_core_reset", core_reset, 0);
    #1 reset = 1'b1;
    #1;
    chk("midrun_rst_core_reset", core_reset, 1);
    chk("midrun_rst_run_cycles", run_cycles, 0);
    chk("midrun_rst_prog_address", prog_address, 0);
    chk("midrun_rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    boot(tbl[0]);
    boot(tbl[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
